pwm_capture: RTL

//  Measures an incoming PWM waveform: period and high time, in CLK cycles.

---
 rtl/pwm_capture_pkg.sv | 20 ++
 rtl/pwm_capture_if.sv | 27 ++
 rtl/pwm_in_sync.sv | 78 +++++++
 rtl/pwm_capture.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM state encoding,
// default parameter values and the counter saturation value.
package pwm_capture_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF    = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_ARM  = 2'd0;
    localparam state_t ST_HIGH = 2'd1;
    localparam state_t ST_LOW  = 2'd2;

    // All-ones value of a counter of the given width
    function automatic logic [31:0] cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Capture-side bus of pwm_capture: PWM input, enable/clear controls and the
// measurement results. The master drives the inputs, the slave is the capture block.
interface pwm_capture_if
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             PWM_IN;
    logic             EN;
    logic             OVF_CLR;
    logic [CNT_W-1:0] PERIOD;
    logic [CNT_W-1:0] HIGH_TIME;
    logic             VALID;
    logic             OVERFLOW;

    modport master (
        output PWM_IN, EN, OVF_CLR,
        input  PERIOD, HIGH_TIME, VALID, OVERFLOW
    );

    modport slave (
        input  PWM_IN, EN, OVF_CLR,
        output PERIOD, HIGH_TIME, VALID, OVERFLOW
    );

endinterface

// File: rtl/pwm_in_sync.sv
// Input conditioning for pwm_capture: synchronizer, optional glitch filter
// (enabled by PWM_CAPTURE_FILTER_EN) and rise/fall edge detection.
module pwm_in_sync
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic                   lvl_s;
    logic                   lvl_d_r;

    // Metastability chain for the asynchronous PWM input
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // FILT_LEN values below 1 are not meaningful; no hardware either way
    if (FILT_LEN < 1) begin : g_filt_len_invalid
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int             FW        = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FW-1:0]  FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [FW-1:0]  FILT_ONE  = FW'(1);

    logic          filt_r;
    logic [FW-1:0] stab_r;

    // Accept a new level only after it has held for FILT_LEN cycles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            filt_r <= 1'b0;
            stab_r <= {FW{1'b0}};
        end else if (sync_s == filt_r) begin
            stab_r <= {FW{1'b0}};
        end else if (stab_r == FILT_LAST) begin
            filt_r <= sync_s;
            stab_r <= {FW{1'b0}};
        end else begin
            stab_r <= stab_r + FILT_ONE;
        end
    end

    assign lvl_s = filt_r;
`else
    assign lvl_s = sync_s;
`endif

    // Previous conditioned level for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lvl_d_r <= 1'b0;
        end else begin
            lvl_d_r <= lvl_s;
        end
    end

    assign level = lvl_s;
    assign rise  = lvl_s & ~lvl_d_r;
    assign fall  = ~lvl_s & lvl_d_r;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time measurement in CLK cycles. Build with
// PWM_CAPTURE_FILTER_EN defined to insert the input glitch filter.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input logic          CLK,
    input logic          RST,
    pwm_capture_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             level_s;
    logic             rise_s;
    logic             fall_s;

    state_t           state_r,     state_s;
    logic [CNT_W-1:0] cnt_r,       cnt_s;
    logic [CNT_W-1:0] high_cap_r,  high_cap_s;
    logic [CNT_W-1:0] period_r,    period_s;
    logic [CNT_W-1:0] high_time_r, high_time_s;
    logic             valid_r,     valid_s;
    logic             ovf_r,       ovf_s;
    logic             ovf_set_s;
    logic             cnt_sat_s;
    logic [CNT_W-1:0] cnt_inc_s;

    pwm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync (
        .CLK    (CLK),
        .RST    (RST),
        .pwm_in (bus.PWM_IN),
        .level  (level_s),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    assign cnt_sat_s = (cnt_r == CNT_MAX);
    assign cnt_inc_s = cnt_sat_s ? cnt_r : (cnt_r + CNT_ONE);

    // Next-state, counter and capture decisions
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        high_cap_s  = high_cap_r;
        period_s    = period_r;
        high_time_s = high_time_r;
        valid_s     = 1'b0;
        ovf_set_s   = 1'b0;
        if (!bus.EN) begin
            state_s = ST_ARM;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_ARM: begin
                    if (rise_s && level_s) begin
                        cnt_s   = CNT_ONE;
                        state_s = ST_HIGH;
                    end else begin
                        cnt_s   = CNT_ZERO;
                        state_s = ST_ARM;
                    end
                end
                ST_HIGH: begin
                    if (fall_s) begin
                        high_cap_s = cnt_r;
                        cnt_s      = cnt_inc_s;
                        state_s    = ST_LOW;
                    end else if (cnt_sat_s) begin
                        ovf_set_s = 1'b1;
                        cnt_s     = CNT_ZERO;
                        state_s   = ST_ARM;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_LOW: begin
                    // A rise closes a complete period: publish it
                    if (rise_s) begin
                        period_s    = cnt_r;
                        high_time_s = high_cap_r;
                        valid_s     = 1'b1;
                        cnt_s       = CNT_ONE;
                        state_s     = ST_HIGH;
                    end else if (cnt_sat_s) begin
                        ovf_set_s = 1'b1;
                        cnt_s     = CNT_ZERO;
                        state_s   = ST_ARM;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                default: begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_ARM;
                end
            endcase
        end
    end

    // Sticky overflow: a new saturation beats a simultaneous clear
    always_comb begin
        if (ovf_set_s) begin
            ovf_s = 1'b1;
        end else if (bus.OVF_CLR) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // State and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_ARM;
            cnt_r       <= CNT_ZERO;
            high_cap_r  <= CNT_ZERO;
            period_r    <= CNT_ZERO;
            high_time_r <= CNT_ZERO;
            valid_r     <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            high_cap_r  <= high_cap_s;
            period_r    <= period_s;
            high_time_r <= high_time_s;
            valid_r     <= valid_s;
            ovf_r       <= ovf_s;
        end
    end

    assign bus.PERIOD    = period_r;
    assign bus.HIGH_TIME = high_time_r;
    assign bus.VALID     = valid_r;
    assign bus.OVERFLOW  = ovf_r;

endmodule
